set_time_ctrl: RTL and testbench
================================

SET_TIME_CTRL -- requirements
Module: set_time_ctrl

Parameters
REQ-001 The block SHALL have parameter REP_DLY, default 16, meaning the cycles an INC_H/INC_M must be held before auto-repeat starts.
REQ-002 The block SHALL have parameter REP_PER, default 4, meaning the cycles between auto-repeat pulses.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the idle cycles in an edit state before abandoning without commit.

Interface
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 CLEAR_N  in  1  reset; asynchronous, active-low.
REQ-006 MODE, CONFIRM, CLR_BTN, SEL_DAY, TOGGLE, INC_H, INC_M  in  1 each  level button inputs, already synchronous to CLK.
REQ-007 S0  out  1  datapath source select: 1 = current-time input, 0 = alarm register.
REQ-008 LD_TIME, LD_DAY, LD_ID, LD_O_F, TOF, IH, IM, CLEAR_ST  out  1 each  single-cycle datapath control pulses.
REQ-009 EN_ST  out  1  counter enable for the datapath; high in every non-IDLE state.
REQ-010 CT_WE  out  1  one-cycle write strobe committing edited time to the running clock.
REQ-011 ALM_WE  out  7  one-hot write strobe for alarm registers r0..r6.
REQ-012 ALM_SEL  out  3  current alarm register index, 0..6.
REQ-013 STATE  out  3  encoded FSM state for display.

Function
REQ-014 All outputs SHALL be registered; a button rising edge sampled at edge k SHALL produce its pulse during cycle k+1.
REQ-015 Press detection SHALL be rising-edge (previous sample 0, current sample 1); exactly one action SHALL be taken per press, except for auto-repeat.
REQ-016 FSM states and encodings SHALL be: IDLE=0, LDT=1, ET=2, CMT_T=3, LDA=4, EA=5, CMT_A=6.
REQ-017 IDLE: all pulses low, EN_ST=0; a MODE press SHALL move the FSM to LDT.
REQ-018 LDT: one cycle with S0=1, LD_TIME=1, LD_DAY=1, LD_O_F=1; then the FSM SHALL move to ET.
REQ-019 ET (S0=1): the following presses SHALL act as shown:
  - INC_H -> IH pulse
  - INC_M -> IM pulse
  - SEL_DAY -> LD_ID pulse
  - CLR_BTN -> CLEAR_ST pulse
  - CONFIRM -> CMT_T
  - MODE -> LDA with ALM_SEL=0
REQ-020 CMT_T: one cycle with CT_WE=1; then the FSM SHALL move to IDLE.
REQ-021 LDA: one cycle with S0=0, LD_TIME=1, LD_O_F=1; then the FSM SHALL move to EA.
REQ-022 EA (S0=0): the following presses SHALL act as shown:
  - INC_H -> IH pulse
  - INC_M -> IM pulse
  - TOGGLE -> TOF pulse
  - CLR_BTN -> CLEAR_ST pulse
  - SEL_DAY -> LD_ID pulse, ALM_SEL incremented, then LDA (reload)
  - CONFIRM -> CMT_A
  - MODE -> IDLE with no write (cancel)
REQ-023 CMT_A: one cycle with ALM_WE[ALM_SEL]=1 (other bits 0); then the FSM SHALL move to IDLE.
REQ-024 ALM_SEL SHALL wrap 6 -> 0; values 7 SHALL never occur.
REQ-025 Press priority in a single cycle SHALL be MODE > CONFIRM > CLR_BTN > SEL_DAY > TOGGLE > INC_H > INC_M; lower-priority edges in that cycle SHALL be discarded.
REQ-026 Auto-repeat: in ET/EA, INC_H or INC_M held continuously SHALL produce the press pulse plus a further pulse REP_DLY cycles after the press, then one every REP_PER cycles until release or state exit; INC_H repeat SHALL take precedence if both are held.
REQ-027 Timeout: in ET/EA, a counter SHALL be cleared on any accepted press or repeat and incremented otherwise; reaching TIMEOUT SHALL move the FSM to IDLE with no CT_WE/ALM_WE.
REQ-028 Presses arriving during the one-cycle states (LDT, LDA, CMT_T, CMT_A) SHALL be ignored.
REQ-029 At most one of IH, IM, LD_ID, TOF, CLEAR_ST SHALL be high in any cycle.

Reset
REQ-030 CLEAR_N low SHALL immediately, regardless of the clock, force: STATE=IDLE, all outputs 0, ALM_SEL=0, and repeat/timeout counters 0.
REQ-031 Edge-detect registers SHALL reset to 1, so a button held through reset release SHALL not register a press.
REQ-032 A reset asserted mid-edit SHALL produce no commit strobe.

Verification
REQ-033 MODE press from IDLE -> LDT for 1 cycle (S0=1, LD_TIME=LD_DAY=LD_O_F=1), then ET with EN_ST=1; a subsequent CONFIRM -> CT_WE high for exactly 1 cycle, then IDLE.
REQ-034 In EA with ALM_SEL=6, a SEL_DAY press -> LD_ID pulse, ALM_SEL=0, LDA for 1 cycle, then EA; CONFIRM -> ALM_WE=7'b0000001.
REQ-035 In ET, INC_M held for 30 cycles with REP_DLY=16 and REP_PER=4 -> IM pulses at offsets 1, 17, 21, 25, 29 only.
REQ-036 In ET, MODE, CONFIRM and INC_H rising in the same cycle -> transition to LDA only, with no IH and no CT_WE.
REQ-037 In EA, no presses for 1024 cycles -> IDLE with ALM_WE never asserted; a CLEAR_N pulse in ET -> all outputs 0 asynchronously, and no pulse on release with buttons held.

Source files
------------

// File: rtl/set_time_ctrl.sv
// Set-time / set-alarm control FSM: debounced-button press decoding, auto-repeat and edit timeout.
// Latency: every output is registered; a press sampled at edge k acts during cycle k+1.
// Backpressure: none; presses arriving in the one-cycle load/commit states are dropped.
module set_time_ctrl #(
  parameter int REP_DLY = 16,
  parameter int REP_PER = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic       CLK,
  input  logic       CLEAR_N,
  input  logic       MODE,
  input  logic       CONFIRM,
  input  logic       CLR_BTN,
  input  logic       SEL_DAY,
  input  logic       TOGGLE,
  input  logic       INC_H,
  input  logic       INC_M,
  output logic       S0,
  output logic       LD_TIME,
  output logic       LD_DAY,
  output logic       LD_ID,
  output logic       LD_O_F,
  output logic       TOF,
  output logic       IH,
  output logic       IM,
  output logic       CLEAR_ST,
  output logic       EN_ST,
  output logic       CT_WE,
  output logic [6:0] ALM_WE,
  output logic [2:0] ALM_SEL,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDT   = 3'd1,
    ET    = 3'd2,
    CMT_T = 3'd3,
    LDA   = 3'd4,
    EA    = 3'd5,
    CMT_A = 3'd6
  } state_t;

  localparam int RW = $clog2(REP_DLY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Button vector ordered by priority: bit 6 (MODE) wins over lower bits.
  logic [6:0] btn;
  logic [6:0] prev_q, prev_d;
  logic [6:0] btn_rise;

  state_t       state_q, state_d;
  logic [2:0]   alm_sel_q, alm_sel_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic s0_q, s0_d, ld_time_q, ld_time_d, ld_day_q, ld_day_d, ld_id_q, ld_id_d;
  logic ld_o_f_q, ld_o_f_d, tof_q, tof_d, ih_q, ih_d, im_q, im_d;
  logic clear_st_q, clear_st_d, en_st_q, en_st_d, ct_we_q, ct_we_d;
  logic [6:0] alm_we_q, alm_we_d;
  logic act;

  assign btn      = {MODE, CONFIRM, CLR_BTN, SEL_DAY, TOGGLE, INC_H, INC_M};
  assign btn_rise = btn & ~prev_q;
  assign prev_d   = btn;

  // Next state, counters and registered-output values (outputs follow the next state).
  always_comb begin
    state_d    = state_q;
    alm_sel_d  = alm_sel_q;
    rep_cnt_d  = '0;
    tmo_cnt_d  = '0;
    ld_id_d    = 1'b0;
    tof_d      = 1'b0;
    ih_d       = 1'b0;
    im_d       = 1'b0;
    clear_st_d = 1'b0;
    act        = 1'b0;
    case (state_q)
      IDLE:  if (btn_rise[6]) state_d = LDT;
      LDT:   state_d = ET;
      LDA:   state_d = EA;
      CMT_T: state_d = IDLE;
      CMT_A: state_d = IDLE;
      ET, EA: begin
        if (btn_rise[6]) begin
          act = 1'b1;
          if (state_q == ET) begin
            state_d   = LDA;
            alm_sel_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (btn_rise[5]) begin
          act     = 1'b1;
          state_d = (state_q == ET) ? CMT_T : CMT_A;
        end else if (btn_rise[4]) begin
          act        = 1'b1;
          clear_st_d = 1'b1;
        end else if (btn_rise[3]) begin
          act     = 1'b1;
          ld_id_d = 1'b1;
          if (state_q == EA) begin
            alm_sel_d = (alm_sel_q == 3'd6) ? 3'd0 : alm_sel_q + 3'd1;
            state_d   = LDA;
          end
        end else if (btn_rise[2] && state_q == EA) begin
          act   = 1'b1;
          tof_d = 1'b1;
        end else if (btn_rise[1]) begin
          act       = 1'b1;
          ih_d      = 1'b1;
          rep_cnt_d = RW'(1);
        end else if (btn_rise[0]) begin
          act       = 1'b1;
          im_d      = 1'b1;
          rep_cnt_d = RW'(1);
        end else if (rep_cnt_q != '0 && (INC_H || INC_M)) begin
          // Counter value equals cycles since the press; first repeat at REP_DLY,
          // then rewind so the next one lands REP_PER cycles later.
          if (rep_cnt_q == RW'(REP_DLY)) begin
            act       = 1'b1;
            ih_d      = INC_H;
            im_d      = ~INC_H;
            rep_cnt_d = RW'(REP_DLY - REP_PER + 1);
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
        if (!act) begin
          if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s0_d      = (state_d == LDT) || (state_d == ET) || (state_d == CMT_T);
    ld_time_d = (state_d == LDT) || (state_d == LDA);
    ld_day_d  = (state_d == LDT);
    ld_o_f_d  = (state_d == LDT) || (state_d == LDA);
    en_st_d   = (state_d != IDLE);
    ct_we_d   = (state_d == CMT_T);
    alm_we_d  = (state_d == CMT_A) ? (7'b0000001 << alm_sel_d) : 7'b0;
  end

  // State, counters, edge-detect history and output registers.
  always_ff @(posedge CLK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      state_q    <= IDLE;
      prev_q     <= '1;
      alm_sel_q  <= 3'd0;
      rep_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      s0_q       <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_day_q   <= 1'b0;
      ld_id_q    <= 1'b0;
      ld_o_f_q   <= 1'b0;
      tof_q      <= 1'b0;
      ih_q       <= 1'b0;
      im_q       <= 1'b0;
      clear_st_q <= 1'b0;
      en_st_q    <= 1'b0;
      ct_we_q    <= 1'b0;
      alm_we_q   <= 7'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      alm_sel_q  <= alm_sel_d;
      rep_cnt_q  <= rep_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      s0_q       <= s0_d;
      ld_time_q  <= ld_time_d;
      ld_day_q   <= ld_day_d;
      ld_id_q    <= ld_id_d;
      ld_o_f_q   <= ld_o_f_d;
      tof_q      <= tof_d;
      ih_q       <= ih_d;
      im_q       <= im_d;
      clear_st_q <= clear_st_d;
      en_st_q    <= en_st_d;
      ct_we_q    <= ct_we_d;
      alm_we_q   <= alm_we_d;
    end
  end

  assign S0       = s0_q;
  assign LD_TIME  = ld_time_q;
  assign LD_DAY   = ld_day_q;
  assign LD_ID    = ld_id_q;
  assign LD_O_F   = ld_o_f_q;
  assign TOF      = tof_q;
  assign IH       = ih_q;
  assign IM       = im_q;
  assign CLEAR_ST = clear_st_q;
  assign EN_ST    = en_st_q;
  assign CT_WE    = ct_we_q;
  assign ALM_WE   = alm_we_q;
  assign ALM_SEL  = alm_sel_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_set_time_ctrl.sv
// Directed bench for set_time_ctrl: edit/commit flows, priority, auto-repeat, timeout, reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// Expected values are hand-derived constants.
module tb_set_time_ctrl;
  logic CLK = 1'b0;
  logic CLEAR_N = 1'b0;
  logic MODE = 0, CONFIRM = 0, CLR_BTN = 0, SEL_DAY = 0, TOGGLE = 0, INC_H = 0, INC_M = 0;
  logic S0, LD_TIME, LD_DAY, LD_ID, LD_O_F, TOF, IH, IM, CLEAR_ST, EN_ST, CT_WE;
  logic [6:0] ALM_WE;
  logic [2:0] ALM_SEL, STATE;

  int errors = 0;
  int checks = 0;

  set_time_ctrl #(.REP_DLY(16), .REP_PER(4), .TIMEOUT(1024)) dut (
    .CLK(CLK), .CLEAR_N(CLEAR_N), .MODE(MODE), .CONFIRM(CONFIRM), .CLR_BTN(CLR_BTN),
    .SEL_DAY(SEL_DAY), .TOGGLE(TOGGLE), .INC_H(INC_H), .INC_M(INC_M),
    .S0(S0), .LD_TIME(LD_TIME), .LD_DAY(LD_DAY), .LD_ID(LD_ID), .LD_O_F(LD_O_F),
    .TOF(TOF), .IH(IH), .IM(IM), .CLEAR_ST(CLEAR_ST), .EN_ST(EN_ST), .CT_WE(CT_WE),
    .ALM_WE(ALM_WE), .ALM_SEL(ALM_SEL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Single-bit controls {S0,LD_TIME,LD_DAY,LD_ID,LD_O_F,TOF,IH,IM,CLEAR_ST,EN_ST,CT_WE}
  wire [10:0] ctl    = {S0, LD_TIME, LD_DAY, LD_ID, LD_O_F, TOF, IH, IM, CLEAR_ST, EN_ST, CT_WE};
  wire [23:0] all_o  = {ctl, ALM_WE, ALM_SEL, STATE};
  wire [4:0]  pulses = {IH, IM, LD_ID, TOF, CLEAR_ST};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int ea_cycles;
    logic alm_seen;
    logic [31:0] exp_im;

    // Reset state
    #2;
    chk("reset_outputs", 32'(all_o), 32'h0);
    @(posedge CLK); #3;
    CLEAR_N = 1'b1;
    step();
    chk("idle_state", 32'(STATE), 32'd0);
    chk("idle_en_st", 32'(EN_ST), 32'd0);

    // IDLE -> LDT -> ET
    MODE = 1; step(); MODE = 0;
    chk("ldt_state", 32'(STATE), 32'd1);
    chk("ldt_ctl", 32'(ctl), 32'b1_1_1_0_1_0_0_0_0_1_0);
    step();
    chk("et_state", 32'(STATE), 32'd2);
    chk("et_ctl", 32'(ctl), 32'b1_0_0_0_0_0_0_0_0_1_0);

    // ET edit presses
    INC_H = 1; step(); INC_H = 0;
    chk("et_ih", 32'(pulses), 32'b10000);
    step();
    chk("et_ih_single", 32'(pulses), 32'b00000);
    SEL_DAY = 1; step(); SEL_DAY = 0;
    chk("et_ld_id", 32'(pulses), 32'b00100);
    chk("et_ld_id_stay", 32'(STATE), 32'd2);
    CLR_BTN = 1; step(); CLR_BTN = 0;
    chk("et_clear_st", 32'(pulses), 32'b00001);
    TOGGLE = 1; step(); TOGGLE = 0;
    chk("et_toggle_ignored", 32'(pulses), 32'b00000);

    // ET CONFIRM -> CMT_T one cycle -> IDLE
    CONFIRM = 1; step(); CONFIRM = 0;
    chk("cmt_t_state", 32'(STATE), 32'd3);
    chk("cmt_t_ct_we", 32'(CT_WE), 32'd1);
    step();
    chk("cmt_t_back_idle", 32'(STATE), 32'd0);
    chk("cmt_t_ct_we_off", 32'(CT_WE), 32'd0);
    chk("idle_en_st_off", 32'(EN_ST), 32'd0);

    // Auto-repeat: INC_M held for 30 cycles in ET
    MODE = 1; step(); MODE = 0; step();
    chk("et2_state", 32'(STATE), 32'd2);
    INC_M = 1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 30) INC_M = 0;
      exp_im = (i == 1 || i == 17 || i == 21 || i == 25 || i == 29) ? 32'd1 : 32'd0;
      chk($sformatf("repeat_im_off%0d", i), 32'(IM), exp_im);
    end

    // MODE + CONFIRM + INC_H together in ET -> LDA only
    MODE = 1; CONFIRM = 1; INC_H = 1; step(); MODE = 0; CONFIRM = 0; INC_H = 0;
    chk("prio_state_lda", 32'(STATE), 32'd4);
    chk("prio_no_ih", 32'(IH), 32'd0);
    chk("prio_no_ct_we", 32'(CT_WE), 32'd0);
    chk("lda_ctl", 32'(ctl), 32'b0_1_0_0_1_0_0_0_0_1_0);
    chk("lda_alm_sel", 32'(ALM_SEL), 32'd0);
    step();
    chk("ea_state", 32'(STATE), 32'd5);
    chk("ea_s0", 32'(S0), 32'd0);

    // EA edit presses
    TOGGLE = 1; step(); TOGGLE = 0;
    chk("ea_tof", 32'(pulses), 32'b00010);
    INC_M = 1; step(); INC_M = 0;
    chk("ea_im", 32'(pulses), 32'b01000);

    // SEL_DAY walks ALM_SEL 1..6 then wraps to 0
    for (int n = 1; n <= 7; n++) begin
      SEL_DAY = 1; step(); SEL_DAY = 0;
      chk($sformatf("sel_day_ld_id_%0d", n), 32'(LD_ID), 32'd1);
      chk($sformatf("sel_day_lda_%0d", n), 32'(STATE), 32'd4);
      chk($sformatf("sel_day_alm_sel_%0d", n), 32'(ALM_SEL), 32'(n % 7));
      step();
      chk($sformatf("sel_day_ea_%0d", n), 32'(STATE), 32'd5);
    end
    CONFIRM = 1; step(); CONFIRM = 0;
    chk("cmt_a_state", 32'(STATE), 32'd6);
    chk("cmt_a_alm_we", 32'(ALM_WE), 32'b0000001);
    step();
    chk("cmt_a_back_idle", 32'(STATE), 32'd0);
    chk("cmt_a_alm_we_off", 32'(ALM_WE), 32'd0);

    // Timeout in EA: 1024 idle cycles then IDLE with no write
    MODE = 1; step(); MODE = 0; step();
    MODE = 1; step(); MODE = 0;
    chk("tmo_lda", 32'(STATE), 32'd4);
    step();
    chk("tmo_ea", 32'(STATE), 32'd5);
    ea_cycles = 1;
    alm_seen = 1'b0;
    for (int i = 0; i < 1100 && STATE == 3'd5; i++) begin
      step();
      if (STATE == 3'd5) ea_cycles++;
      if (ALM_WE != 7'd0) alm_seen = 1'b1;
    end
    chk("tmo_ea_cycles", 32'(ea_cycles), 32'd1024);
    chk("tmo_idle", 32'(STATE), 32'd0);
    chk("tmo_no_alm_we", 32'(alm_seen), 32'd0);

    // Asynchronous reset mid-edit with buttons held through release
    MODE = 1; step(); MODE = 0; step();
    chk("rst_pre_et", 32'(STATE), 32'd2);
    INC_H = 1; MODE = 1;
    #2;
    CLEAR_N = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(all_o), 32'h0);
    @(posedge CLK); #3;
    CLEAR_N = 1'b1;
    step();
    chk("rst_held_no_press", 32'(all_o), 32'h0);
    step();
    chk("rst_held_still_idle", 32'(STATE), 32'd0);
    MODE = 0; INC_H = 0; step();
    MODE = 1; step(); MODE = 0;
    chk("rst_recover_ldt", 32'(STATE), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
